// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the controller/ALU and the load/store unit.
// The controller side drives requests (master); the load/store unit answers (slave).
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req_valid, MemRead, MemWrite, funct3, addr, wdata,
      input  req_ready, resp_valid, rdata, err
   );

   modport slave (
      input  req_valid, MemRead, MemWrite, funct3, addr, wdata,
      output req_ready, resp_valid, rdata, err
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store sequencer in front of a word-wide, single-write-enable data RAM.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module mem_access_unit #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.slave  bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RESP} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        req_err;
   logic        is_load_p0;
   logic [2:0]  f3_p0;
   logic [1:0]  off_p0;
   logic [15:0] wdata_p0;

   function automatic logic req_error(input logic        mr,
                                      input logic        mw,
                                      input logic [2:0]  f3,
                                      input logic [31:0] a);
      logic bad_f3;
      logic misaligned;
      logic out_of_range;
      if (mw)
         bad_f3 = (f3 > 3'b010);
      else
         bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      misaligned   = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
      out_of_range = (a[31:ADDR_W+2] != '0);
      return (mr && mw) || bad_f3 || misaligned || out_of_range;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [15:0] wd,
                                               input logic [1:0]  off,
                                               input logic        half);
      logic [31:0] m;
      m = old;
      if (half) begin
         if (off[1])
            m[31:16] = wd;
         else
            m[15:0] = wd;
      end else begin
         m[{off, 3'b000} +: 8] = wd[7:0];
      end
      return m;
   endfunction

   assign req_err = req_error(bus.MemRead, bus.MemWrite, bus.funct3, bus.addr);
   assign accept  = bus.req_valid && (state == IDLE) && (bus.MemRead || bus.MemWrite);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Handshake strobes and RAM write enable are pure decodes of the state, so
   // an asynchronous reset drops mem_we immediately.
   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      mem_we         = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (accept) begin
               if (req_err)
                  state_nxt = RESP;
               else if (bus.MemWrite && (bus.funct3 == 3'b010))
                  state_nxt = WRITE;
               else
                  state_nxt = ADDR;
            end
         end
         ADDR:  state_nxt = DATA;
         DATA:  state_nxt = is_load_p0 ? RESP : WRITE;
         WRITE: begin
            mem_we    = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture at acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         is_load_p0 <= bus.MemRead;
         f3_p0      <= bus.funct3;
         off_p0     <= bus.addr[1:0];
         wdata_p0   <= bus.wdata[15:0];
      end
   end

   // RAM address/data and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         bus.rdata <= '0;
         bus.err   <= 1'b0;
      end else begin
         if (accept) begin
            mem_addr <= bus.addr[ADDR_W+1:2];
            if (bus.MemWrite)
               mem_wdata <= bus.wdata;
            if (req_err) begin
               bus.rdata <= '0;
               bus.err   <= 1'b1;
            end
         end
         if (state == DATA) begin
            if (is_load_p0) begin
               bus.rdata <= load_extend(mem_rdata, off_p0, f3_p0);
               bus.err   <= 1'b0;
            end else begin
               mem_wdata <= store_merge(mem_rdata, wdata_p0, off_p0, f3_p0[0]);
            end
         end
         if (state == WRITE) begin
            bus.rdata <= '0;
            bus.err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: a byte-level reference model
// predicts every response and every RAM write, a monitor compares them as they appear.
module tb_mem_access_unit;
   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic [31:0]       mem_rdata;

   mem_access_unit_if bif ();

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bif),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] ram     [0:(1<<ADDR_W)-1];
   logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          at;
   } resp_t;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   resp_t rq[$];
   wr_t   wq[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the queued predictions
   always @(negedge clk) begin
      if (rst_n) begin
         if (bif.resp_valid) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: got resp_valid=1 expected none (t=%0t)", $time);
            end else begin
               resp_t e;
               e = rq.pop_front();
               chk("resp_rdata", bif.rdata, e.rdata);
               chk("resp_err", {31'b0, bif.err}, {31'b0, e.err});
               chk("resp_cycle", cyc, e.at);
            end
         end
         if (mem_we) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL write_unexpected: got mem_we=1 addr=%h data=%h expected none", mem_addr, mem_wdata);
            end else begin
               wr_t w;
               w = wq.pop_front();
               chk("write_addr", {18'b0, mem_addr}, {18'b0, w.a});
               chk("write_data", mem_wdata, w.d);
            end
         end
      end
   end

   // Reference model: byte-lane arithmetic on a word array, with latency in
   // cycles counted from the accept edge.
   task automatic predict(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int acc);
      int          nbits;
      int          sh;
      logic [31:0] mask;
      logic [31:0] w;
      logic [31:0] v;
      logic        bad;
      resp_t       r;
      wr_t         wr;
      nbits = (f3[1:0] == 2'b00) ? 8 : (f3[1:0] == 2'b01) ? 16 : 32;
      sh    = 8 * int'(a % 4);
      bad   = mr && mw;
      if (mw && f3 > 3'd2) bad = 1'b1;
      if (mr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) bad = 1'b1;
      if (nbits == 16 && (a % 2) != 0) bad = 1'b1;
      if (nbits == 32 && (a % 4) != 0) bad = 1'b1;
      if ((a >> (ADDR_W + 2)) != 0) bad = 1'b1;
      mask = (nbits == 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 1);
      if (bad) begin
         r = '{rdata: 32'h0, err: 1'b1, at: acc};
      end else if (mr) begin
         w = ref_mem[a / 4];
         v = (w >> sh) & mask;
         if (!f3[2] && nbits < 32 && ((v >> (nbits - 1)) & 1) == 1) v = v | ~mask;
         r = '{rdata: v, err: 1'b0, at: acc + 2};
      end else begin
         w = ref_mem[a / 4];
         v = (w & ~(mask << sh)) | ((wd & mask) << sh);
         ref_mem[a / 4] = v;
         wr.a = ADDR_W'(a / 4);
         wr.d = v;
         wq.push_back(wr);
         r = '{rdata: 32'h0, err: 1'b0, at: acc + ((nbits == 32) ? 1 : 3)};
      end
      rq.push_back(r);
   endtask

   task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit track);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bif.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bif.req_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
         return;
      end
      bif.req_valid = 1'b1;
      bif.MemRead   = mr;
      bif.MemWrite  = mw;
      bif.funct3    = f3;
      bif.addr      = a;
      bif.wdata     = wd;
      if (track && (mr || mw)) predict(mr, mw, f3, a, wd, cyc + 1);
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      bif.MemRead   = 1'b0;
      bif.MemWrite  = 1'b0;
      if (!mr && !mw) chk("no_type_stays_idle", {31'b0, bif.req_ready}, 32'h1);
   endtask

   initial begin
      bif.req_valid = 1'b0;
      bif.MemRead   = 1'b0;
      bif.MemWrite  = 1'b0;
      bif.funct3    = 3'b0;
      bif.addr      = '0;
      bif.wdata     = '0;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         logic [31:0] v;
         v = (i < 32) ? $urandom : 32'h0;
         if (i == 5) v = 32'h8899AABB;
         ram[i] <= v;
         ref_mem[i] = v;
      end
      #3;
      chk("rst_req_ready", {31'b0, bif.req_ready}, 32'h1);
      chk("rst_resp_valid", {31'b0, bif.resp_valid}, 32'h0);
      chk("rst_rdata", bif.rdata, 32'h0);
      chk("rst_err", {31'b0, bif.err}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_addr", {18'b0, mem_addr}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(1, 0, 3'b000, 32'h17, 32'h0, 1);          // lb  -> FFFFFF88
      issue(1, 0, 3'b101, 32'h16, 32'h0, 1);          // lhu -> 00008899
      issue(1, 0, 3'b001, 32'h14, 32'h0, 1);          // lh  -> FFFFAABB
      issue(0, 1, 3'b000, 32'h15, 32'h123, 1);        // sb  -> 889923BB
      issue(0, 1, 3'b010, 32'h14, 32'h8899AABB, 1);   // restore word 5
      issue(0, 1, 3'b001, 32'h16, 32'h7777, 1);       // sh  -> 7777AABB
      issue(0, 1, 3'b010, 32'h20, 32'hDEADBEEF, 1);
      issue(1, 0, 3'b010, 32'h20, 32'h0, 1);
      issue(1, 0, 3'b010, 32'h22, 32'h0, 1);          // misaligned lw
      issue(0, 1, 3'b001, 32'h13, 32'h55, 1);         // misaligned sh
      issue(1, 0, 3'b010, 32'h0001_0000, 32'h0, 1);   // out of range
      issue(1, 1, 3'b010, 32'h20, 32'h1, 1);          // both read and write
      issue(0, 1, 3'b100, 32'h20, 32'h1, 1);          // store with load-only funct3
      issue(1, 0, 3'b111, 32'h20, 32'h0, 1);          // undefined funct3
      issue(0, 0, 3'b010, 32'h20, 32'h0, 1);          // no access type

      // Reset during the read phase of an sb: the write must never happen
      issue(0, 1, 3'b000, 32'h14, 32'hEE, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("midrst_resp_valid", {31'b0, bif.resp_valid}, 32'h0);
      chk("midrst_req_ready", {31'b0, bif.req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue(1, 0, 3'b010, 32'h14, 32'h0, 1);          // word 5 still 7777AABB

      for (int n = 0; n < 250; n++) begin
         int          k;
         logic        mr;
         logic        mw;
         logic [2:0]  f3;
         logic [31:0] a;
         k  = $urandom_range(0, 19);
         mr = (k < 11) || (k == 19);
         mw = (k >= 11);
         if (k == 18) begin
            mr = 1'b0;
            mw = 1'b0;
         end
         if ($urandom_range(0, 9) < 8) begin
            int s;
            s  = $urandom_range(0, mw ? 2 : 4);
            f3 = (s > 2) ? 3'(s + 1) : 3'(s);
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a = a | (32'h1_0000 << $urandom_range(0, 15));
         issue(mr, mw, f3, a, $urandom, 1);
      end

      for (int i = 0; i < 100 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
      chk("resp_queue_drained", rq.size(), 32'h0);
      chk("write_queue_drained", wq.size(), 32'h0);
      for (int i = 0; i < 16; i++) chk($sformatf("ram_word_%0d", i), ram[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
